// File: rtl/alu_seq_ctrl_if.sv
// Request/response bundle for the sequential ALU.
// master drives the request side, slave produces the result side.
interface alu_seq_ctrl_if #(
   parameter int WIDTH = 16
) ();
   logic             start;
   logic [2:0]       opcode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             carry;
   logic             zero;
   logic             err;

   modport master (
      output start, opcode, a, b,
      input  ready, done, result, result_hi, carry, zero, err
   );

   modport slave (
      input  start, opcode, a, b,
      output ready, done, result, result_hi, carry, zero, err
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequential ALU: single-cycle logic/arith ops plus 16-step MUL/DIV.
// Define ALU_SEQ_DIV_EN to build the restoring divider for opcode 111.
module alu_seq_ctrl #(
   parameter int WIDTH = 16
) (
   input logic           clk,
   input logic           rst,
   alu_seq_ctrl_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_DIV = 3'b111;

   typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [2:0]       op;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] hi, lo;
   logic [WIDTH-1:0] result, result_hi;
   logic             carry, zero, err, done, ready;

   logic             iter_op;
   logic [WIDTH-1:0] nxt_hi, nxt_lo;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] res, res_hi;
   logic             res_c, res_e;

   assign bus.ready     = ready;
   assign bus.done      = done;
   assign bus.result    = result;
   assign bus.result_hi = result_hi;
   assign bus.carry     = carry;
   assign bus.zero      = zero;
   assign bus.err       = err;

   always_comb begin
      iter_op = (bus.opcode == OP_MUL);
`ifdef ALU_SEQ_DIV_EN
      if (bus.opcode == OP_DIV && bus.b != '0)
         iter_op = 1'b1;
`endif
   end

   // hi:lo is the product register (MUL) or remainder:quotient (DIV)
`ifdef ALU_SEQ_DIV_EN
   logic [WIDTH:0] rem_t, diff;
`endif
   always_comb begin
      nxt_hi = hi;
      nxt_lo = lo;
      sum    = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
`ifdef ALU_SEQ_DIV_EN
      rem_t  = {hi, lo[WIDTH-1]};
      diff   = rem_t - {1'b0, b_q};
`endif
      if (op == OP_MUL) begin
         nxt_hi = sum[WIDTH:1];
         nxt_lo = {sum[0], lo[WIDTH-1:1]};
      end
`ifdef ALU_SEQ_DIV_EN
      else if (!diff[WIDTH]) begin
         nxt_hi = diff[WIDTH-1:0];
         nxt_lo = {lo[WIDTH-2:0], 1'b1};
      end else begin
         nxt_hi = rem_t[WIDTH-1:0];
         nxt_lo = {lo[WIDTH-2:0], 1'b0};
      end
`endif
   end

   always_comb begin
      res    = '0;
      res_hi = '0;
      res_c  = 1'b0;
      res_e  = 1'b0;
      unique case (op)
         OP_ADD: {res_c, res} = {1'b0, a_q} + {1'b0, b_q};
         OP_SUB: begin
            res   = a_q - b_q;
            res_c = (a_q < b_q);
         end
         OP_AND: res = a_q & b_q;
         OP_OR:  res = a_q | b_q;
         OP_XOR: res = a_q ^ b_q;
         OP_NOT: res = ~a_q;
         OP_MUL: res = '0;
         OP_DIV: begin
`ifdef ALU_SEQ_DIV_EN
            res    = '1;
            res_hi = a_q;
`endif
            res_e  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         op        <= '0;
         a_q       <= '0;
         b_q       <= '0;
         hi        <= '0;
         lo        <= '0;
         result    <= '0;
         result_hi <= '0;
         carry     <= 1'b0;
         zero      <= 1'b0;
         err       <= 1'b0;
         done      <= 1'b0;
         ready     <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               op    <= bus.opcode;
               a_q   <= bus.a;
               b_q   <= bus.b;
               cnt   <= '0;
               ready <= 1'b0;
               hi    <= '0;
               lo    <= bus.a;
               state <= iter_op ? ITER : EXEC;
            end
            EXEC: begin
               result    <= res;
               result_hi <= res_hi;
               carry     <= res_c;
               zero      <= (res == '0);
               err       <= res_e;
               done      <= 1'b1;
               state     <= DONE;
            end
            ITER: begin
               hi  <= nxt_hi;
               lo  <= nxt_lo;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  result    <= nxt_lo;
                  result_hi <= nxt_hi;
                  carry     <= 1'b0;
                  zero      <= (nxt_lo == '0);
                  err       <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               ready <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: vector table plus multi-cycle sequences.
// Latency j means done is high when rising edge k+j samples it.
module tb_alu_seq_ctrl;
   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010;
   localparam logic [2:0] OR_ = 3'b011, XOR_ = 3'b100, NOT_ = 3'b101;
   localparam logic [2:0] MUL = 3'b110, DIV = 3'b111;

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a, b, res, hi;
      logic        c, z, e;
      int          lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   passed = 0;
   vec_t vecs[$];

   alu_seq_ctrl_if #(.WIDTH(16)) bus ();
   alu_seq_ctrl #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic [2:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] res,
                               input logic [15:0] hi, input logic c,
                               input logic z, input logic e, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.res = res; v.hi = hi;
      v.c = c; v.z = z; v.e = e; v.lat = lat;
      return v;
   endfunction

   task automatic check_outs(input string n, input logic [15:0] res,
                             input logic [15:0] hi, input logic c,
                             input logic z, input logic e);
      check({n, " result"}, 32'(bus.result), 32'(res));
      check({n, " result_hi"}, 32'(bus.result_hi), 32'(hi));
      check({n, " carry"}, 32'(bus.carry), 32'(c));
      check({n, " zero"}, 32'(bus.zero), 32'(z));
      check({n, " err"}, 32'(bus.err), 32'(e));
   endtask

   task automatic run_vec(input string n, input vec_t v);
      int lat;
      @(negedge clk);
      bus.start = 1'b1; bus.opcode = v.op; bus.a = v.a; bus.b = v.b;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.opcode = ~v.op;
      bus.a = ~v.a; bus.b = v.a ^ 16'h5A5A;
      lat = 0;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         if (bus.done) begin lat = j; break; end
      end
      check({n, " latency"}, 32'(lat), 32'(v.lat));
      check_outs(n, v.res, v.hi, v.c, v.z, v.e);
      check({n, " ready in DONE"}, 32'(bus.ready), 32'd0);
      @(negedge clk);
      check({n, " done pulse width"}, 32'(bus.done), 32'd0);
      check({n, " ready after"}, 32'(bus.ready), 32'd1);
   endtask

   initial begin
      int lat, nd, d1, d2;
      logic [15:0] r1, r2;
      logic rd3, rd4;

      vecs.push_back(mk(ADD, 16'd756, 16'd3080, 16'd3836, 0, 0, 0, 0, 2));
      vecs.push_back(mk(SUB, 16'd5, 16'd7, 16'hFFFE, 0, 1, 0, 0, 2));
      vecs.push_back(mk(SUB, 16'd9, 16'd9, 16'd0, 0, 0, 1, 0, 2));
      vecs.push_back(mk(AND_, 16'hF0F0, 16'h0FF0, 16'h00F0, 0, 0, 0, 0, 2));
      vecs.push_back(mk(OR_, 16'hF0F0, 16'h0FF0, 16'hFFF0, 0, 0, 0, 0, 2));
      vecs.push_back(mk(XOR_, 16'hF0F0, 16'h0FF0, 16'hFF00, 0, 0, 0, 0, 2));
      vecs.push_back(mk(NOT_, 16'h1234, 16'h9999, 16'hEDCB, 0, 0, 0, 0, 2));
      vecs.push_back(mk(ADD, 16'hFFFF, 16'h0001, 16'h0000, 0, 1, 1, 0, 2));
      vecs.push_back(mk(MUL, 16'd300, 16'd300, 16'h5F90, 16'h0001, 0, 0, 0, 17));
      vecs.push_back(mk(MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 0, 0, 17));
      vecs.push_back(mk(MUL, 16'd0, 16'h1234, 16'h0000, 16'h0000, 0, 1, 0, 17));
`ifdef ALU_SEQ_DIV_EN
      vecs.push_back(mk(DIV, 16'd1000, 16'd7, 16'd142, 16'd6, 0, 0, 0, 17));
      vecs.push_back(mk(DIV, 16'd1000, 16'd0, 16'hFFFF, 16'd1000, 0, 0, 1, 2));
      vecs.push_back(mk(DIV, 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 0, 0, 0, 17));
`else
      vecs.push_back(mk(DIV, 16'd1000, 16'd7, 16'd0, 16'd0, 0, 1, 1, 2));
      vecs.push_back(mk(DIV, 16'd1000, 16'd0, 16'd0, 16'd0, 0, 1, 1, 2));
`endif

      bus.start = 1'b0; bus.opcode = '0; bus.a = '0; bus.b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset ready", 32'(bus.ready), 32'd1);
      check("reset done", 32'(bus.done), 32'd0);
      check_outs("reset", 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

      // MUL with stray start pulses at k+3 and k+10
      @(negedge clk);
      bus.start = 1'b1; bus.opcode = MUL; bus.a = 16'd300; bus.b = 16'd300;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.a = 16'd1; bus.b = 16'd1; bus.opcode = ADD;
      lat = 0;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         bus.start = (j == 3 || j == 10);
         if (bus.done) begin lat = j; break; end
      end
      bus.start = 1'b0;
      check("mul_ign latency", 32'(lat), 32'd17);
      check_outs("mul_ign", 16'h5F90, 16'h0001, 1'b0, 1'b0, 1'b0);
      nd = 0;
      for (int j = 0; j < 25; j++) begin
         @(negedge clk);
         if (bus.done) nd++;
      end
      check("mul_ign no queued op", 32'(nd), 32'd0);

      // reset at k+8 of a MUL, then rst together with start in IDLE
      @(negedge clk);
      bus.start = 1'b1; bus.opcode = MUL; bus.a = 16'd300; bus.b = 16'd300;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int j = 1; j <= 8; j++) @(negedge clk);
      rst = 1'b1; bus.start = 1'b1; bus.opcode = ADD;
      bus.a = 16'd1; bus.b = 16'd1;
      @(posedge clk); #1;
      check("rst_mid ready", 32'(bus.ready), 32'd1);
      check("rst_mid done", 32'(bus.done), 32'd0);
      check_outs("rst_mid", 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("rst_vs_start ready", 32'(bus.ready), 32'd1);
      rst = 1'b0; bus.start = 1'b0;
      nd = 0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (bus.done) nd++;
      end
      check("rst_mid no done", 32'(nd), 32'd0);
      check("rst_mid result held", 32'(bus.result), 32'd0);
      run_vec("and_after_rst",
              mk(AND_, 16'hF0F0, 16'h0FF0, 16'h00F0, 0, 0, 0, 0, 2));

      // start held high: back-to-back ops with one IDLE cycle between
      @(negedge clk);
      bus.start = 1'b1; bus.opcode = ADD; bus.a = 16'd1; bus.b = 16'd2;
      @(posedge clk); #1;
      bus.a = 16'd10; bus.b = 16'd20;
      d1 = 0; d2 = 0; r1 = '0; r2 = '0; rd3 = 1'b0; rd4 = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         @(negedge clk);
         if (j == 3) rd3 = bus.ready;
         if (j == 4) rd4 = bus.ready;
         if (bus.done) begin
            if (d1 == 0) begin
               d1 = j; r1 = bus.result;
            end else if (d2 == 0) begin
               d2 = j; r2 = bus.result; bus.start = 1'b0;
            end
         end
      end
      bus.start = 1'b0;
      check("b2b first done", 32'(d1), 32'd2);
      check("b2b first result", 32'(r1), 32'd3);
      check("b2b idle ready", 32'(rd3), 32'd1);
      check("b2b busy ready", 32'(rd4), 32'd0);
      check("b2b second done", 32'(d2), 32'd5);
      check("b2b second result", 32'(r2), 32'd30);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
